// File: rtl/led_pkg.sv
// led_pkg: shared types and defaults for the LED frame controller.
//   state_e          - frame controller FSM states
//   rgb_t            - 24-bit pixel as sent to the serializer
//   LATCH_CYCLES_DEF - default post-frame latch gap (50 us at 48 MHz)
//   GAP_CNT_W        - width of the gap down-counter
package led_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_LO,
    ST_RD_HI,
    ST_CAP_HI,
    ST_PRESENT,
    ST_GAP
  } state_e;

  typedef logic [23:0] rgb_t;

  localparam int LATCH_CYCLES_DEF = 2400;
  localparam int GAP_CNT_W        = 24;

endpackage

// File: rtl/led_frame_ctrl_gap_timer.sv
// gap_timer: down-counter that times the post-frame latch gap.
//   clk, reset - clock and asynchronous active-low reset
//   load       - load LOAD_VAL-1 (the cycle before the gap starts)
//   en         - high for every gap cycle; counts down while non-zero
//   expire     - high in the last of LOAD_VAL enabled cycles
module gap_timer
  import led_pkg::*;
#(
  parameter int CNT_W    = GAP_CNT_W,
  parameter int LOAD_VAL = LATCH_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expire
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CNT_W'(LOAD_VAL - 1);
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Counter starts at LOAD_VAL-1, so reaching zero marks the LOAD_VAL-th cycle.
  assign expire = en && (cnt_q == '0);

endmodule

// File: rtl/led_frame_ctrl.sv
// led_frame_ctrl: reads NUM_LEDS pixels (two SPRAM words each) and hands them
// to an LED serializer, then holds a latch gap. Host writes share the SPRAM
// port and are granted only while idle or in the gap.
//   clk, reset                 - clock, asynchronous active-low reset
//   wr_req/wr_addr/wr_data     - host write, held until wr_ack pulses
//   frame_start                - refresh request (remembered one-deep if busy)
//   busy, frame_done           - status; frame_done pulses after the gap
//   mem_addr/mem_wdata/mem_we  - SPRAM port; mem_rdata arrives one cycle later
//   pix_rgb/pix_valid/pix_ready- pixel stream to the serializer
//   dbg_state                  - current FSM state
// Handshake: a pixel transfers in a cycle where pix_valid and pix_ready are
// both high; pix_valid and pix_rgb stay stable until that cycle.
module led_frame_ctrl
  import led_pkg::*;
#(
  parameter int          NUM_LEDS     = 8,
  parameter logic [13:0] BASE_ADDR    = 14'd0,
  parameter int          LATCH_CYCLES = LATCH_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_req,
  input  logic [13:0] wr_addr,
  input  logic [15:0] wr_data,
  output logic        wr_ack,
  input  logic        frame_start,
  output logic        busy,
  output logic        frame_done,
  output logic [13:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  input  logic [15:0] mem_rdata,
  output rgb_t        pix_rgb,
  output logic        pix_valid,
  input  logic        pix_ready,
  output state_e      dbg_state
);

  localparam int IDX_W = 12;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              pend_q, pend_d;
  logic [15:0]       lo_q, lo_d;
  logic [7:0]        hi_q, hi_d;
  logic              done_q, done_d;

  logic              grant;
  logic              gap_load;
  logic              gap_expire;
  logic              last_pix;
  logic [13:0]       lo_addr;
  logic [13:0]       hi_addr;

  // 14-bit sums wrap naturally past the top of the SPRAM.
  assign lo_addr  = BASE_ADDR + {1'b0, idx_q, 1'b0};
  assign hi_addr  = lo_addr + 14'd1;
  assign last_pix = (idx_q == IDX_W'(NUM_LEDS - 1));
  assign grant    = wr_req && ((state_q == ST_IDLE) || (state_q == ST_GAP));

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pend_d    = pend_q | frame_start;
    lo_d      = lo_q;
    hi_d      = hi_q;
    done_d    = 1'b0;
    gap_load  = 1'b0;
    mem_addr  = BASE_ADDR;
    mem_wdata = 16'd0;
    mem_we    = 1'b0;
    wr_ack    = 1'b0;
    pix_valid = 1'b0;

    if (grant) begin
      mem_addr  = wr_addr;
      mem_wdata = wr_data;
      mem_we    = 1'b1;
      wr_ack    = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        // A granted write owns the port; a coinciding start stays pending.
        if (!grant && (frame_start || pend_q)) begin
          state_d = ST_RD_LO;
          idx_d   = '0;
          pend_d  = 1'b0;
        end
      end
      ST_RD_LO: begin
        mem_addr = lo_addr;
        state_d  = ST_RD_HI;
      end
      ST_RD_HI: begin
        mem_addr = hi_addr;
        lo_d     = mem_rdata;
        state_d  = ST_CAP_HI;
      end
      ST_CAP_HI: begin
        mem_addr = hi_addr;
        hi_d     = mem_rdata[7:0];
        state_d  = ST_PRESENT;
      end
      ST_PRESENT: begin
        // Address held on the hi word so a stall shows no port activity.
        mem_addr  = hi_addr;
        pix_valid = 1'b1;
        if (pix_ready) begin
          if (last_pix) begin
            state_d  = ST_GAP;
            gap_load = 1'b1;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_RD_LO;
          end
        end
      end
      ST_GAP: begin
        if (gap_expire) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      pend_q  <= 1'b0;
      lo_q    <= 16'd0;
      hi_q    <= 8'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      done_q  <= done_d;
    end
  end

  gap_timer #(
    .CNT_W   (GAP_CNT_W),
    .LOAD_VAL(LATCH_CYCLES)
  ) u_gap_timer (
    .clk   (clk),
    .reset (reset),
    .load  (gap_load),
    .en    (state_q == ST_GAP),
    .expire(gap_expire)
  );

  assign pix_rgb    = {hi_q, lo_q};
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = done_q;
  assign dbg_state  = state_q;

endmodule
